// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, width helper and the hex-to-7-segment table for the scan driver.
// Segment order is {g,f,e,d,c,b,a}; all patterns are active-low.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side value/control bus and board-side segment/anode pins of the scan driver.
// master = producer of digits and controls, slave = the driver itself.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, dp_in, load, digit_en, lz_blank, blink_mask,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, load, digit_en, lz_blank, blink_mask,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg_scan_driver_lut.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Zero latency; no handshake.
module hex_to_seg_lut
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous double buffering.
// Outputs registered one clk after the scan index / shadow buffer they reflect; no backpressure.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int FRM_W = cnt_width(BLINK_FRAMES);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = 1;

    logic [CNT_W-1:0]        presc;
    logic [IDX_W-1:0]        idx;
    logic [FRM_W-1:0]        frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] pend_val, shadow_val;
    logic [NUM_DIGITS-1:0]   pend_dp, shadow_dp;
    logic                    pending_valid;
    logic                    wrap_q;

    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_done_q;

    logic                    tc, boundary;
    logic [NUM_DIGITS-1:0]   upper_zero, blank_vec;
    logic [3:0]              cur_nib;
    logic [6:0]              cur_seg;
    logic                    cur_blank;

    assign tc       = (presc == CNT_W'(REFRESH_DIV - 1));
    assign boundary = tc && (idx == IDX_W'(NUM_DIGITS - 1));

    // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the shadow value are all zero
    always_comb begin
        upper_zero = '0;
        blank_vec  = '0;
        upper_zero[NUM_DIGITS-1] = (shadow_val[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            upper_zero[i] = upper_zero[i+1] && (shadow_val[4*i +: 4] == 4'h0);
        for (int i = 0; i < NUM_DIGITS; i++)
            blank_vec[i] = !bus.digit_en[i]
                         || (bus.lz_blank && (i > 0) && upper_zero[i])
                         || (bus.blink_mask[i] && blink_phase);
    end

    assign cur_nib   = shadow_val[{idx, 2'b00} +: 4];
    assign cur_blank = blank_vec[idx];

    hex_to_seg_lut u_lut (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc         <= '0;
            idx           <= '0;
            frame_cnt     <= '0;
            blink_phase   <= 1'b0;
            pend_val      <= '0;
            pend_dp       <= '0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
            pending_valid <= 1'b0;
            wrap_q        <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            presc  <= tc ? '0 : presc + 1'b1;
            wrap_q <= boundary;
            if (tc)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

            if (boundary) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // A load coinciding with the boundary bypasses pending and wins over it
            if (boundary && bus.load) begin
                shadow_val    <= bus.value;
                shadow_dp     <= bus.dp_in;
                pending_valid <= 1'b0;
            end else if (boundary && pending_valid) begin
                shadow_val    <= pend_val;
                shadow_dp     <= pend_dp;
                pending_valid <= 1'b0;
            end else if (bus.load) begin
                pend_val      <= bus.value;
                pend_dp       <= bus.dp_in;
                pending_valid <= 1'b1;
            end

            frame_done_q <= wrap_q;
            if (cur_blank) begin
                an_q  <= '1;
                seg_q <= SEG_BLANK;
                dp_q  <= 1'b1;
            end else begin
                an_q  <= ~(AN_ONE << idx);
                seg_q <= cur_seg;
                dp_q  <= !shadow_dp[idx];
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 4 clk per slot, 2 frames per blink half).
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nfd = 0;
    int   viol = 0;

    seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // frame_done pulses since reset == frame boundaries taken
    always @(posedge clk) begin
        if (!rst_n) nfd <= 0;
        else if (bus.frame_done) nfd <= nfd + 1;
    end

    always @(negedge clk)
        if ($countones(~bus.an) > 1) viol = viol + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_frame(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_frame_timeout"}, {31'd0, found}, 32'd1);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp_in = d;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // segs = {slot3,slot2,slot1,slot0}; lit/dps per slot; blink0 applies the blink model to digit 0
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                               input logic [3:0] dps, input logic blink0);
        logic [3:0] l;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         phase;
        wait_frame(tag);
        phase = ((nfd + 1) / 2) % 2;
        l = lit;
        if (blink0 && phase == 1) l[0] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (4) @(negedge clk);
            e_an  = l[s] ? ~(4'b0001 << s) : 4'hF;
            e_seg = l[s] ? segs[s*7 +: 7] : 7'h7F;
            e_dp  = !(l[s] && dps[s]);
            chk($sformatf("%s_an_s%0d", tag, s), {28'd0, bus.an}, {28'd0, e_an});
            chk($sformatf("%s_seg_s%0d", tag, s), {25'd0, bus.seg}, {25'd0, e_seg});
            chk($sformatf("%s_dp_s%0d", tag, s), {31'd0, bus.dp}, {31'd0, e_dp});
        end
    endtask

    initial begin
        int gap;
        bus.value = '0;
        bus.dp_in = '0;
        bus.load = 1'b0;
        bus.digit_en = 4'hF;
        bus.lz_blank = 1'b0;
        bus.blink_mask = 4'h0;

        // 1. reset values, first update, scan order and frame period
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, bus.an}, 32'hF);
        chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("rst_dp", {31'd0, bus.dp}, 32'd1);
        chk("rst_fd", {31'd0, bus.frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an", {28'd0, bus.an}, 32'hE);
        chk("first_seg", {25'd0, bus.seg}, 32'h40);
        check_frame("t1", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 1'b0);
        wait_frame("t1_gap_a");
        @(negedge clk);
        chk("fd_one_cycle", {31'd0, bus.frame_done}, 32'd0);
        gap = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (bus.frame_done === 1'b1) break;
        end
        chk("fd_period", gap, 32'd16);

        // 2. mid-frame load is deferred to the boundary; last load wins
        repeat (5) @(negedge clk);
        pulse_load(16'h12AF, 4'h0);
        repeat (2) @(negedge clk);
        chk("t2_hold_an", {28'd0, bus.an}, 32'hB);
        chk("t2_hold_seg", {25'd0, bus.seg}, 32'h40);
        check_frame("t2a", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'h0, 1'b0);
        pulse_load(16'h3333, 4'h0);
        pulse_load(16'h0005, 4'h0);
        check_frame("t2b", {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 4'h0, 1'b0);

        // 3. leading-zero suppression
        bus.lz_blank = 1'b1;
        pulse_load(16'h0050, 4'h0);
        check_frame("t3a", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0011, 4'h0, 1'b0);
        pulse_load(16'h0000, 4'h0);
        check_frame("t3b", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'h0, 1'b0);
        pulse_load(16'h0B96, 4'h0);
        check_frame("t3c", {7'h7F, 7'h03, 7'h10, 7'h02}, 4'b0111, 4'h0, 1'b0);

        // 4. blink on digit 0, decimal point on digit 1
        bus.lz_blank = 1'b0;
        bus.blink_mask = 4'b0001;
        pulse_load(16'h1234, 4'b0010);
        for (int f = 0; f < 4; f++)
            check_frame($sformatf("t4_f%0d", f), {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'b0010, 1'b1);
        bus.blink_mask = 4'h0;

        // 5. load on the exact boundary cycle goes straight to shadow
        wait_frame("t5");
        repeat (14) @(negedge clk);
        pulse_load(16'hC7E8, 4'h0);
        chk("t5_pending", {31'd0, dut.pending_valid}, 32'd0);
        check_frame("t5", {7'h46, 7'h78, 7'h06, 7'h00}, 4'hF, 4'h0, 1'b0);

        // 6. reset mid-frame discards pending value
        wait_frame("t6");
        @(negedge clk);
        pulse_load(16'h9999, 4'h0);
        repeat (7) @(negedge clk);
        chk("t6_pre_an", {28'd0, bus.an}, 32'hB);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_an", {28'd0, bus.an}, 32'hF);
        chk("t6_rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("t6_rst_dp", {31'd0, bus.dp}, 32'd1);
        chk("t6_rst_fd", {31'd0, bus.frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_restart_an", {28'd0, bus.an}, 32'hE);
        chk("t6_restart_seg", {25'd0, bus.seg}, 32'h40);
        chk("t6_pending", {31'd0, dut.pending_valid}, 32'd0);
        check_frame("t6", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 1'b0);

        chk("an_onehot", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
